// File: rtl/des_key_schedule.sv
// DES key schedule: emits the 16 round subkeys one at a time, rotating C/D in place.
// Ports: Clk, Reset (sync, high), Load/Key/Decrypt start a schedule, Next advances;
//   Sub_Key/Round/Key_Valid describe the current subkey, Done and Key_Err are pulses.
module des_key_schedule #(
    parameter bit PARITY_CHECK = 1'b0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Load,
    input  logic [63:0] Key,
    input  logic        Decrypt,
    input  logic        Next,
    output logic [47:0] Sub_Key,
    output logic [3:0]  Round,
    output logic        Key_Valid,
    output logic        Done,
    output logic        Key_Err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } state_t;

    localparam int PC1_TBL [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TBL [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    // DES numbers bits from 1 at the MSB, so DES bit n of a W-bit
    // vector lives at index W-n.
    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [55:0] r;
        r = '0;
        for (int i = 0; i < 56; i++) begin
            r[6'(55 - i)] = k[6'(64 - PC1_TBL[i])];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [47:0] r;
        r = '0;
        for (int i = 0; i < 48; i++) begin
            r[6'(47 - i)] = cd[6'(56 - PC2_TBL[i])];
        end
        return r;
    endfunction

    // Rounds 1, 2, 9 and 16 use a single-bit rotation, all others two.
    function automatic logic single_shift(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16);
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction

    function automatic logic odd_parity_ok(input logic [63:0] k);
        logic ok;
        ok = 1'b1;
        for (int b = 0; b < 8; b++) begin
            ok = ok & (^k[8*b +: 8]);
        end
        return ok;
    endfunction

    state_t      state_q, state_d;
    logic [27:0] c_q, c_d;
    logic [27:0] d_q, d_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;
    logic        key_err_q;

    logic        load_ok;
    logic        load_rej;
    logic [55:0] cd_load;
    logic        shift_one;

    always_comb begin
        load_ok  = Load && (!PARITY_CHECK || odd_parity_ok(Key));
        load_rej = Load && !load_ok;
        cd_load  = pc1(Key);
        // Encrypt walks r -> r+1 using s[r+1]; decrypt undoes s[17-r].
        if (dec_q) begin
            shift_one = single_shift(5'd17 - {1'b0, round_q});
        end else begin
            shift_one = single_shift({1'b0, round_q} + 5'd1);
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dec_d   = dec_q;
        if (load_ok) begin
            // Decrypt starts at K16, whose C/D equal the unrotated PC-1 halves.
            if (Decrypt) begin
                c_d = cd_load[55:28];
                d_d = cd_load[27:0];
            end else begin
                c_d = rotl(cd_load[55:28], 1'b1);
                d_d = rotl(cd_load[27:0], 1'b1);
            end
            round_d = 4'd1;
            dec_d   = Decrypt;
            state_d = ST_ACTIVE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_ACTIVE: begin
                    if (Next) begin
                        if (round_q == 4'd15 + 4'd1) begin
                            round_d = 4'd0;
                            state_d = ST_DONE;
                        end else if (dec_q) begin
                            c_d     = rotr(c_q, shift_one);
                            d_d     = rotr(d_q, shift_one);
                            round_d = round_q + 4'd1;
                        end else begin
                            c_d     = rotl(c_q, shift_one);
                            d_d     = rotl(d_q, shift_one);
                            round_d = round_q + 4'd1;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            c_q       <= '0;
            d_q       <= '0;
            round_q   <= '0;
            dec_q     <= 1'b0;
            key_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            c_q       <= c_d;
            d_q       <= d_d;
            round_q   <= round_d;
            dec_q     <= dec_d;
            key_err_q <= load_rej;
        end
    end

    assign Sub_Key   = pc2({c_q, d_q});
    assign Round     = round_q;
    assign Key_Valid = (state_q == ST_ACTIVE);
    assign Done      = (state_q == ST_DONE);
    assign Key_Err   = key_err_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the classic 133457799BBCDFF1 key.
// Two instances: default build and one with odd-parity checking enabled.
module tb_des_key_schedule;

    localparam logic [63:0] KEY = 64'h133457799BBCDFF1;
    localparam logic [47:0] K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] K2  = 48'h79AED9DBC9E5;
    localparam logic [47:0] K3  = 48'h55FC8A42CF99;
    localparam logic [47:0] K7  = 48'hEC84B7F618BC;
    localparam logic [47:0] K9  = 48'hE0DBEBEDE781;
    localparam logic [47:0] K15 = 48'hBF918D3D3F0A;
    localparam logic [47:0] K16 = 48'hCB3D8B0E17F5;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [63:0] key = '0;
    logic        decrypt = 1'b0;
    logic        nxt = 1'b0;
    logic [47:0] sub_key;
    logic [3:0]  round;
    logic        key_valid;
    logic        done;
    logic        key_err;

    logic        p_load = 1'b0;
    logic [63:0] p_key = '0;
    logic        p_next = 1'b0;
    logic [47:0] p_sub_key;
    logic [3:0]  p_round;
    logic        p_key_valid;
    logic        p_done;
    logic        p_key_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    des_key_schedule u_dut (
        .Clk(clk), .Reset(reset), .Load(load), .Key(key),
        .Decrypt(decrypt), .Next(nxt), .Sub_Key(sub_key),
        .Round(round), .Key_Valid(key_valid), .Done(done),
        .Key_Err(key_err)
    );

    des_key_schedule #(.PARITY_CHECK(1'b1)) u_par (
        .Clk(clk), .Reset(reset), .Load(p_load), .Key(p_key),
        .Decrypt(1'b0), .Next(p_next), .Sub_Key(p_sub_key),
        .Round(p_round), .Key_Valid(p_key_valid), .Done(p_done),
        .Key_Err(p_key_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (round !== 4'd0) begin
            errors++; $display("FAIL reset_round got %0d exp 0", round);
        end
        checks++;
        if (key_valid !== 1'b0 || done !== 1'b0 || key_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got kv=%b d=%b ke=%b exp 000", key_valid, done, key_err);
        end
        checks++;
        if (sub_key !== 48'h0) begin
            errors++; $display("FAIL reset_subkey got %h exp 0", sub_key);
        end
        checks++;
        if (p_round !== 4'd0 || p_key_valid !== 1'b0 || p_key_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_par got r=%0d kv=%b ke=%b exp 0 0 0", p_round, p_key_valid, p_key_err);
        end
    endtask

    task automatic test_encrypt();
        key = KEY; decrypt = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (key_valid !== 1'b1 || round !== 4'd1 || sub_key !== K1) begin
            errors++;
            $display("FAIL enc_k1 got kv=%b r=%0d %h exp 1 1 %h", key_valid, round, sub_key, K1);
        end
        nxt = 1'b1;
        step();
        checks++;
        if (round !== 4'd2 || sub_key !== K2) begin
            errors++; $display("FAIL enc_k2 got r=%0d %h exp 2 %h", round, sub_key, K2);
        end
        step();
        checks++;
        if (round !== 4'd3 || sub_key !== K3) begin
            errors++; $display("FAIL enc_k3 got r=%0d %h exp 3 %h", round, sub_key, K3);
        end
        for (int i = 0; i < 13; i++) step();
        checks++;
        if (round !== 4'd15 + 4'd1 || sub_key !== K16 || key_valid !== 1'b1) begin
            errors++; $display("FAIL enc_k16 got r=%0d %h exp 16 %h", round, sub_key, K16);
        end
        step();
        checks++;
        if (done !== 1'b1 || key_valid !== 1'b0 || round !== 4'd0) begin
            errors++;
            $display("FAIL enc_done got d=%b kv=%b r=%0d exp 1 0 0", done, key_valid, round);
        end
        step();
        checks++;
        if (done !== 1'b0 || key_valid !== 1'b0 || round !== 4'd0) begin
            errors++;
            $display("FAIL enc_idle got d=%b kv=%b r=%0d exp 0 0 0", done, key_valid, round);
        end
        step();
        nxt = 1'b0;
        checks++;
        if (done !== 1'b0 || key_valid !== 1'b0) begin
            errors++; $display("FAIL idle_next got d=%b kv=%b exp 0 0", done, key_valid);
        end
    endtask

    task automatic test_decrypt();
        key = KEY; decrypt = 1'b1; load = 1'b1;
        step();
        load = 1'b0;
        decrypt = 1'b0;
        checks++;
        if (key_valid !== 1'b1 || round !== 4'd1 || sub_key !== K16) begin
            errors++;
            $display("FAIL dec_r1 got kv=%b r=%0d %h exp 1 1 %h", key_valid, round, sub_key, K16);
        end
        nxt = 1'b1;
        step();
        checks++;
        if (round !== 4'd2 || sub_key !== K15) begin
            errors++; $display("FAIL dec_r2 got r=%0d %h exp 2 %h", round, sub_key, K15);
        end
        for (int i = 0; i < 12; i++) step();
        checks++;
        if (round !== 4'd14 || sub_key !== K3) begin
            errors++; $display("FAIL dec_r14 got r=%0d %h exp 14 %h", round, sub_key, K3);
        end
        step();
        step();
        checks++;
        if (round !== 4'd15 + 4'd1 || sub_key !== K1) begin
            errors++; $display("FAIL dec_r16 got r=%0d %h exp 16 %h", round, sub_key, K1);
        end
        step();
        nxt = 1'b0;
        checks++;
        if (done !== 1'b1 || key_valid !== 1'b0) begin
            errors++; $display("FAIL dec_done got d=%b kv=%b exp 1 0", done, key_valid);
        end
        step();
    endtask

    task automatic test_load_override();
        key = KEY; decrypt = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        nxt = 1'b1;
        for (int i = 0; i < 6; i++) step();
        checks++;
        if (round !== 4'd7 || sub_key !== K7) begin
            errors++; $display("FAIL ovr_k7 got r=%0d %h exp 7 %h", round, sub_key, K7);
        end
        load = 1'b1;
        step();
        load = 1'b0;
        nxt = 1'b0;
        checks++;
        if (round !== 4'd1 || sub_key !== K1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ovr_reload got r=%0d %h d=%b exp 1 %h 0", round, sub_key, done, K1);
        end
        step();
        checks++;
        if (round !== 4'd1 || key_valid !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL ovr_hold got r=%0d kv=%b d=%b exp 1 1 0", round, key_valid, done);
        end
    endtask

    task automatic test_reset_mid();
        key = KEY; decrypt = 1'b0; load = 1'b1;
        step();
        load = 1'b0;
        nxt = 1'b1;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (round !== 4'd9 || sub_key !== K9) begin
            errors++; $display("FAIL mid_k9 got r=%0d %h exp 9 %h", round, sub_key, K9);
        end
        reset = 1'b1;
        load = 1'b1;
        step();
        reset = 1'b0;
        load = 1'b0;
        checks++;
        if (round !== 4'd0 || key_valid !== 1'b0 || done !== 1'b0 || sub_key !== 48'h0) begin
            errors++;
            $display("FAIL mid_reset got r=%0d kv=%b d=%b %h exp 0 0 0 0", round, key_valid, done, sub_key);
        end
        step();
        step();
        nxt = 1'b0;
        checks++;
        if (round !== 4'd0 || key_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_next got r=%0d kv=%b d=%b exp 0 0 0", round, key_valid, done);
        end
    endtask

    task automatic test_parity();
        p_key = 64'h0;
        p_load = 1'b1;
        step();
        p_load = 1'b0;
        checks++;
        if (p_key_err !== 1'b1 || p_key_valid !== 1'b0 || p_round !== 4'd0) begin
            errors++;
            $display("FAIL par_reject got ke=%b kv=%b r=%0d exp 1 0 0", p_key_err, p_key_valid, p_round);
        end
        step();
        checks++;
        if (p_key_err !== 1'b0 || p_key_valid !== 1'b0) begin
            errors++; $display("FAIL par_pulse got ke=%b kv=%b exp 0 0", p_key_err, p_key_valid);
        end
        p_key = KEY;
        p_load = 1'b1;
        step();
        p_load = 1'b0;
        checks++;
        if (p_key_err !== 1'b0 || p_key_valid !== 1'b1 || p_round !== 4'd1 || p_sub_key !== K1) begin
            errors++;
            $display("FAIL par_accept got ke=%b kv=%b r=%0d %h exp 0 1 1 %h",
                     p_key_err, p_key_valid, p_round, p_sub_key, K1);
        end
        p_key = 64'h0;
        p_load = 1'b1;
        p_next = 1'b1;
        step();
        p_load = 1'b0;
        p_next = 1'b0;
        checks++;
        if (p_key_err !== 1'b1 || p_round !== 4'd2 || p_sub_key !== K2) begin
            errors++;
            $display("FAIL par_active got ke=%b r=%0d %h exp 1 2 %h", p_key_err, p_round, p_sub_key, K2);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        step();
        test_reset();
        test_encrypt();
        test_decrypt();
        test_load_override();
        test_reset_mid();
        test_parity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
